vt_text_writer: RTL and testbench
=================================

Name: vt_text_writer

Overview:
- Single-writer controller for the 80x60 character text RAM scanned by the VGA character display.
- Takes a byte stream through a valid/ready handshake and interprets VT100-style control codes: CR, LF, BS, autowrap and scroll.
- Produces one-per-cycle RAM write strobes and maintains a circular top-row offset, so a scroll is a pointer bump plus a single-line clear, not a screen copy.
- The display scanner adds top_row to its row index modulo ROWS.

Parameters:
- COLS, 80, characters per row.
- ROWS, 60, character rows (480/8).
- ADDR_W, 13, text RAM address width; ROWS*COLS must be <= 2^ADDR_W.
- BLANK, 8'h20, fill byte used for clears.

Ports:
- clk25  in  1  pixel/system clock, all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- char_valid  in  1  char_data holds a byte to consume.
- char_data  in  8  byte to interpret.
- char_ready  out  1  block can accept a byte this cycle.
- clear_req  in  1  single-cycle pulse: clear screen, home cursor.
- mem_we  out  1  write strobe to text RAM (registered).
- mem_waddr  out  ADDR_W  physical write address (registered).
- mem_wdata  out  8  write data (registered).
- top_row  out  6  physical row currently displayed at screen row 0.
- cursor_col  out  7  logical cursor column, 0..COLS-1.
- cursor_row  out  6  logical cursor row, 0..ROWS-1.
- busy  out  1  high in any clear state.

Behaviour:
- Reset (async): state IDLE; mem_we=0, mem_waddr=0, mem_wdata=0; top_row=0; cursor 0,0; clr_pending=0.
- States: IDLE, CLR_LINE, CLR_ALL.
- char_ready = (state==IDLE) && !clear_req && !clr_pending. Combinational.
- Accept occurs on a cycle with char_valid && char_ready. All effects are registered and visible on the next edge (latency 1).
- Physical address: prow = cursor_row+top_row, minus ROWS if the sum is >= ROWS. addr = prow*COLS + cursor_col. Multiply by a constant; no divider.
- Printable byte 0x20..0x7E:
  - mem_we=1 with addr/data for exactly one cycle.
  - cursor_col++.
  - If cursor_col was COLS-1: col=0 and a line feed is applied in the same update.
- CR 0x0D: col=0. No write.
- LF 0x0A: row<ROWS-1 gives row++. Otherwise the row stays at ROWS-1 and a scroll occurs.
- BS 0x08: col-- if col>0, else no change. No write.
- Any other byte is consumed and ignored.
- Scroll:
  - top_row <= (top_row+1) mod ROWS.
  - Go to CLR_LINE targeting physical row = old top_row (the new bottom row).
  - CLR_LINE issues COLS consecutive writes of BLANK, one per cycle, addresses old_top*COLS .. old_top*COLS+COLS-1. It then returns to IDLE.
  - For a scroll triggered by LF, the first clear write is in cycle N+1 (N = accept cycle).
  - For autowrap scroll, the character write occupies N+1 and the clears occupy N+2..N+COLS+1.
- Clear screen:
  - clear_req in IDLE enters CLR_ALL next cycle and takes priority over a same-cycle char_valid; the byte is not accepted.
  - CLR_ALL writes BLANK to addresses 0..ROWS*COLS-1, one per cycle.
  - On exit: top_row=0, cursor 0,0, IDLE.
  - clear_req arriving in CLR_LINE or CLR_ALL sets clr_pending. The current operation finishes, then CLR_ALL runs once; multiple pulses collapse into one.
- mem_we is low in every cycle not listed above. Never more than one write per cycle.
- Counters wrap only as stated; the cursor never leaves 0..COLS-1 / 0..ROWS-1.
- rst asserted mid-clear aborts immediately to reset state. RAM contents are left partially cleared (acceptable).

Test Plan:
- Reset, send 'A' (0x41) at cycle N → mem_we=1 at N+1, addr=0, data=0x41; cursor_col=1; char_ready stays 1.
- Send 80 printable bytes on row 0 → 80th write at addr 79; cursor becomes col 0, row 1; no scroll, top_row=0.
- Cursor at row 59, send LF at N → top_row=1 at N+1; writes of 0x20 to addrs 0..79 over N+1..N+80; char_ready=0 throughout and 1 at N+81; cursor_row=59.
- After the scroll above (top_row=1), cursor row 59 col 5, send 'Z' → write addr ((59+1) mod 60)*80+5 = 5.
- Send CR then BS at col 0 → cursor_col 0, no mem_we. Send 0x07 → consumed, no write, cursor unchanged.
- clear_req and char_valid in the same IDLE cycle → byte not accepted; 4800 writes to addrs 0..4799; second clear_req mid-clear → exactly one more 4800-write pass; end with top_row=0, cursor 0,0.

Source files
------------

// File: rtl/vt_text_writer.sv
`default_nettype none
// ============================================================================
// Module      : vt_text_writer
// Description : Single-writer controller for the character text RAM. Consumes
//               a byte stream, interprets CR/LF/BS, autowraps, and scrolls by
//               bumping a circular top-row offset and clearing one line.
// Revision    : 1.0 - initial release
// ============================================================================
module vt_text_writer #(
    parameter int         COLS   = 80,
    parameter int         ROWS   = 60,
    parameter int         ADDR_W = 13,
    parameter logic [7:0] BLANK  = 8'h20
) (
    input  logic              clk25,
    input  logic              rst,
    input  logic              char_valid,
    input  logic [7:0]        char_data,
    output logic              char_ready,
    input  logic              clear_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [7:0]        mem_wdata,
    output logic [5:0]        top_row,
    output logic [6:0]        cursor_col,
    output logic [5:0]        cursor_row,
    output logic              busy
);

    localparam int unsigned TOTAL = ROWS * COLS;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CLR_LINE = 2'd1,
        S_CLR_ALL  = 2'd2
    } state_t;

    state_t            state_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_waddr_q;
    logic [7:0]        mem_wdata_q;
    logic [5:0]        top_row_q;
    logic [6:0]        cursor_col_q;
    logic [5:0]        cursor_row_q;
    logic              clr_pending_q;
    logic [ADDR_W-1:0] clr_addr_q;   // next address the clear engine writes
    logic [ADDR_W-1:0] clr_left_q;   // clear writes still to issue

    logic [6:0]        w_row_sum;
    logic [5:0]        w_prow;
    logic [ADDR_W-1:0] w_char_addr;
    logic [ADDR_W-1:0] w_top_base;
    logic [5:0]        w_top_next;
    logic              w_at_bottom;
    logic              w_at_last_col;
    logic              w_printable;
    logic              w_accept;

    // Logical cursor row mapped to the physical row through the circular offset
    assign w_row_sum     = {1'b0, cursor_row_q} + {1'b0, top_row_q};
    assign w_prow        = (w_row_sum >= 7'(ROWS)) ? 6'(w_row_sum - 7'(ROWS)) : w_row_sum[5:0];
    assign w_char_addr   = ADDR_W'(w_prow) * ADDR_W'(COLS) + ADDR_W'(cursor_col_q);
    // The current top row becomes the new bottom row after a scroll
    assign w_top_base    = ADDR_W'(top_row_q) * ADDR_W'(COLS);
    assign w_top_next    = (top_row_q == 6'(ROWS - 1)) ? 6'd0 : top_row_q + 6'd1;
    assign w_at_bottom   = (cursor_row_q == 6'(ROWS - 1));
    assign w_at_last_col = (cursor_col_q == 7'(COLS - 1));
    assign w_printable   = (char_data >= 8'h20) && (char_data <= 8'h7E);

    assign char_ready = (state_q == S_IDLE) && !clear_req && !clr_pending_q;
    assign w_accept   = char_valid && char_ready;

    assign mem_we     = mem_we_q;
    assign mem_waddr  = mem_waddr_q;
    assign mem_wdata  = mem_wdata_q;
    assign top_row    = top_row_q;
    assign cursor_col = cursor_col_q;
    assign cursor_row = cursor_row_q;
    assign busy       = (state_q != S_IDLE);

    // Byte interpreter, line/screen clear engine and registered RAM port
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            mem_we_q      <= 1'b0;
            mem_waddr_q   <= '0;
            mem_wdata_q   <= 8'h00;
            top_row_q     <= 6'd0;
            cursor_col_q  <= 7'd0;
            cursor_row_q  <= 6'd0;
            clr_pending_q <= 1'b0;
            clr_addr_q    <= '0;
            clr_left_q    <= '0;
        end else begin
            mem_we_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (clear_req) begin
                        state_q    <= S_CLR_ALL;
                        clr_addr_q <= '0;
                        clr_left_q <= ADDR_W'(TOTAL);
                    end else if (w_accept) begin
                        if (w_printable) begin
                            mem_we_q    <= 1'b1;
                            mem_waddr_q <= w_char_addr;
                            mem_wdata_q <= char_data;
                            if (w_at_last_col) begin
                                cursor_col_q <= 7'd0;
                                if (!w_at_bottom) begin
                                    cursor_row_q <= cursor_row_q + 6'd1;
                                end else begin
                                    // Character write owns this cycle; all COLS clears follow
                                    top_row_q  <= w_top_next;
                                    state_q    <= S_CLR_LINE;
                                    clr_addr_q <= w_top_base;
                                    clr_left_q <= ADDR_W'(COLS);
                                end
                            end else begin
                                cursor_col_q <= cursor_col_q + 7'd1;
                            end
                        end else if (char_data == 8'h0D) begin
                            cursor_col_q <= 7'd0;
                        end else if (char_data == 8'h0A) begin
                            if (!w_at_bottom) begin
                                cursor_row_q <= cursor_row_q + 6'd1;
                            end else begin
                                // Issue the first clear right away so it lands at accept+1
                                top_row_q   <= w_top_next;
                                state_q     <= S_CLR_LINE;
                                mem_we_q    <= 1'b1;
                                mem_waddr_q <= w_top_base;
                                mem_wdata_q <= BLANK;
                                clr_addr_q  <= w_top_base + ADDR_W'(1);
                                clr_left_q  <= ADDR_W'(COLS - 1);
                            end
                        end else if (char_data == 8'h08) begin
                            if (cursor_col_q != 7'd0) begin
                                cursor_col_q <= cursor_col_q - 7'd1;
                            end
                        end
                    end
                end
                S_CLR_LINE, S_CLR_ALL: begin
                    if (clear_req) begin
                        clr_pending_q <= 1'b1;
                    end
                    if (clr_left_q != '0) begin
                        mem_we_q    <= 1'b1;
                        mem_waddr_q <= clr_addr_q;
                        mem_wdata_q <= BLANK;
                        clr_addr_q  <= clr_addr_q + ADDR_W'(1);
                        clr_left_q  <= clr_left_q - ADDR_W'(1);
                    end else begin
                        if (state_q == S_CLR_ALL) begin
                            top_row_q    <= 6'd0;
                            cursor_col_q <= 7'd0;
                            cursor_row_q <= 6'd0;
                        end
                        // Any number of clear requests seen meanwhile collapse into one pass
                        if (clear_req || clr_pending_q) begin
                            state_q       <= S_CLR_ALL;
                            clr_pending_q <= 1'b0;
                            clr_addr_q    <= '0;
                            clr_left_q    <= ADDR_W'(TOTAL);
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vt_text_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_vt_text_writer
// Description : Self-checking bench for vt_text_writer: a vector table for
//               single-cycle byte handling plus sequences for wrap, scroll,
//               screen clear and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vt_text_writer;

    logic        clk25 = 1'b0;
    logic        rst = 1'b1;
    logic        char_valid = 1'b0;
    logic [7:0]  char_data = 8'h00;
    logic        char_ready;
    logic        clear_req = 1'b0;
    logic        mem_we;
    logic [12:0] mem_waddr;
    logic [7:0]  mem_wdata;
    logic [5:0]  top_row;
    logic [6:0]  cursor_col;
    logic [5:0]  cursor_row;
    logic        busy;

    int n_chk = 0;
    int n_fail = 0;

    vt_text_writer dut (
        .clk25      (clk25),
        .rst        (rst),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .clear_req  (clear_req),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .top_row    (top_row),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    always #20 clk25 = ~clk25;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       we;
        int         addr;
        logic [7:0] wd;
        int         col;
        int         row;
        logic       rdy;
    } vec_t;

    vec_t vec [14];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk25);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        char_valid = 1'b0;
        clear_req = 1'b0;
        repeat (2) @(posedge clk25);
        #1;
        rst = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        char_valid = 1'b1;
        char_data = b;
        tick();
        char_valid = 1'b0;
    endtask

    initial begin
        int err;
        int wcnt;
        logic done;

        vec[0]  = '{1'b0, 8'h00, 1'b0,  0, 8'h00, 0, 0, 1'b1};
        vec[1]  = '{1'b1, 8'h41, 1'b1,  0, 8'h41, 1, 0, 1'b1};
        vec[2]  = '{1'b0, 8'h00, 1'b0,  0, 8'h00, 1, 0, 1'b1};
        vec[3]  = '{1'b1, 8'h0D, 1'b0,  0, 8'h00, 0, 0, 1'b1};
        vec[4]  = '{1'b1, 8'h08, 1'b0,  0, 8'h00, 0, 0, 1'b1};
        vec[5]  = '{1'b1, 8'h07, 1'b0,  0, 8'h00, 0, 0, 1'b1};
        vec[6]  = '{1'b1, 8'h0A, 1'b0,  0, 8'h00, 0, 1, 1'b1};
        vec[7]  = '{1'b1, 8'h62, 1'b1, 80, 8'h62, 1, 1, 1'b1};
        vec[8]  = '{1'b1, 8'h08, 1'b0,  0, 8'h00, 0, 1, 1'b1};
        vec[9]  = '{1'b1, 8'h7E, 1'b1, 80, 8'h7E, 1, 1, 1'b1};
        vec[10] = '{1'b1, 8'h7F, 1'b0,  0, 8'h00, 1, 1, 1'b1};
        vec[11] = '{1'b1, 8'h1F, 1'b0,  0, 8'h00, 1, 1, 1'b1};
        vec[12] = '{1'b1, 8'h20, 1'b1, 81, 8'h20, 2, 1, 1'b1};
        vec[13] = '{1'b1, 8'h0D, 1'b0,  0, 8'h00, 0, 1, 1'b1};

        // Reset state
        do_reset();
        chk("rst_we", int'(mem_we), 0);
        chk("rst_addr", int'(mem_waddr), 0);
        chk("rst_data", int'(mem_wdata), 0);
        chk("rst_top", int'(top_row), 0);
        chk("rst_col", int'(cursor_col), 0);
        chk("rst_row", int'(cursor_row), 0);
        chk("rst_ready", int'(char_ready), 1);
        chk("rst_busy", int'(busy), 0);

        // Single-cycle byte handling from the vector table
        for (int i = 0; i < 14; i++) begin
            char_valid = vec[i].v;
            char_data = vec[i].d;
            #1;
            chk($sformatf("v%0d_ready", i), int'(char_ready), int'(vec[i].rdy));
            tick();
            chk($sformatf("v%0d_we", i), int'(mem_we), int'(vec[i].we));
            if (vec[i].we) begin
                chk($sformatf("v%0d_addr", i), int'(mem_waddr), vec[i].addr);
                chk($sformatf("v%0d_data", i), int'(mem_wdata), int'(vec[i].wd));
            end
            chk($sformatf("v%0d_col", i), int'(cursor_col), vec[i].col);
            chk($sformatf("v%0d_row", i), int'(cursor_row), vec[i].row);
            chk($sformatf("v%0d_top", i), int'(top_row), 0);
        end
        char_valid = 1'b0;

        // 80 printables on row 0: last lands at addr 79, cursor wraps to row 1
        do_reset();
        err = 0;
        for (int i = 0; i < 80; i++) begin
            send(8'h30 + 8'(i % 10));
            if (!mem_we || mem_waddr != 13'(i) || mem_wdata != 8'h30 + 8'(i % 10)) err++;
        end
        chk("row0_writes_bad", err, 0);
        chk("wrap_col", int'(cursor_col), 0);
        chk("wrap_row", int'(cursor_row), 1);
        chk("wrap_top", int'(top_row), 0);
        chk("wrap_ready", int'(char_ready), 1);

        // Walk down to the bottom row without scrolling
        for (int i = 0; i < 58; i++) send(8'h0A);
        chk("bottom_row", int'(cursor_row), 59);
        chk("bottom_top", int'(top_row), 0);

        // LF on the bottom row: scroll with clears at N+1..N+80
        char_valid = 1'b1;
        char_data = 8'h0A;
        tick();
        char_valid = 1'b0;
        chk("lf_top", int'(top_row), 1);
        chk("lf_first_we", int'(mem_we), 1);
        chk("lf_first_addr", int'(mem_waddr), 0);
        chk("lf_first_data", int'(mem_wdata), 32);
        chk("lf_ready_low", int'(char_ready), 0);
        chk("lf_row", int'(cursor_row), 59);
        err = 0;
        for (int k = 1; k < 80; k++) begin
            tick();
            if (!mem_we || mem_waddr != 13'(k) || mem_wdata != 8'h20 || char_ready) err++;
        end
        chk("lf_clear_bad", err, 0);
        tick();
        chk("lf_end_we", int'(mem_we), 0);
        chk("lf_end_ready", int'(char_ready), 1);
        chk("lf_end_row", int'(cursor_row), 59);

        // Character on row 59 after one scroll maps to physical row 0
        for (int i = 0; i < 5; i++) send(8'h2E);
        send(8'h5A);
        chk("z_we", int'(mem_we), 1);
        chk("z_addr", int'(mem_waddr), 5);
        chk("z_data", int'(mem_wdata), 8'h5A);

        // Autowrap scroll: char write at N+1, clears of row 1 at N+2..N+81
        for (int i = 6; i < 79; i++) send(8'h2B);
        chk("pre_wrap_col", int'(cursor_col), 79);
        send(8'h21);
        chk("aw_we", int'(mem_we), 1);
        chk("aw_addr", int'(mem_waddr), 79);
        chk("aw_data", int'(mem_wdata), 8'h21);
        chk("aw_top", int'(top_row), 2);
        chk("aw_col", int'(cursor_col), 0);
        chk("aw_row", int'(cursor_row), 59);
        chk("aw_ready", int'(char_ready), 0);
        err = 0;
        for (int k = 0; k < 80; k++) begin
            tick();
            if (!mem_we || mem_waddr != 13'(80 + k) || mem_wdata != 8'h20) err++;
        end
        chk("aw_clear_bad", err, 0);
        tick();
        chk("aw_end_we", int'(mem_we), 0);
        chk("aw_end_ready", int'(char_ready), 1);

        // Clear beats a same-cycle byte; two pulses mid-clear give one extra pass
        clear_req = 1'b1;
        char_valid = 1'b1;
        char_data = 8'h51;
        #1;
        chk("clr_ready", int'(char_ready), 0);
        tick();
        clear_req = 1'b0;
        char_valid = 1'b0;
        chk("clr_no_write", int'(mem_we), 0);
        chk("clr_busy", int'(busy), 1);
        err = 0;
        wcnt = 0;
        done = 1'b0;
        for (int c = 0; c < 12000 && !done; c++) begin
            tick();
            clear_req = 1'b0;
            if (mem_we) begin
                if (mem_waddr != 13'(wcnt % 4800) || mem_wdata != 8'h20) err++;
                wcnt++;
            end
            if (!busy) done = 1'b1;
            if (c == 100 || c == 300) clear_req = 1'b1;
        end
        clear_req = 1'b0;
        chk("clr_finished", int'(done), 1);
        chk("clr_writes", wcnt, 9600);
        chk("clr_seq_bad", err, 0);
        chk("clr_top", int'(top_row), 0);
        chk("clr_col", int'(cursor_col), 0);
        chk("clr_row", int'(cursor_row), 0);
        chk("clr_ready_end", int'(char_ready), 1);

        // Asynchronous reset aborts a clear in progress
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (20) tick();
        chk("abort_busy_pre", int'(busy), 1);
        #5;
        rst = 1'b1;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_we", int'(mem_we), 0);
        chk("abort_addr", int'(mem_waddr), 0);
        tick();
        rst = 1'b0;
        #1;
        chk("abort_ready", int'(char_ready), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
